// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry instruction FIFO feeding a MIPS32 decoder whose
// results are held in a ready/valid output register for the issue stage.
module decode_queue #(
  parameter int DEPTH     = 4,
  parameter bit RI_STRICT = 1'b1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_ins,
  input  logic [31:0]              in_pc,
  input  logic                     in_adel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [5:0]               out_ALUop,
  output logic [6:0]               out_Rs,
  output logic [6:0]               out_Rt,
  output logic [6:0]               out_Rd,
  output logic [15:0]              out_imm,
  output logic                     out_ri,
  output logic                     out_adel,
  output logic                     out_is_branch,
  output logic                     out_in_delay_slot,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // ALU operation encoding shared with the execute stage
  localparam logic [5:0] ALU_NOP = 6'd0,  ALU_ADD = 6'd1,  ALU_ADDU = 6'd2,  ALU_SUB = 6'd3;
  localparam logic [5:0] ALU_SUBU = 6'd4, ALU_AND = 6'd5,  ALU_OR = 6'd6,    ALU_XOR = 6'd7;
  localparam logic [5:0] ALU_NOR = 6'd8,  ALU_SLT = 6'd9,  ALU_SLTU = 6'd10, ALU_SLL = 6'd11;
  localparam logic [5:0] ALU_SRL = 6'd12, ALU_SRA = 6'd13, ALU_SLLV = 6'd14, ALU_SRLV = 6'd15;
  localparam logic [5:0] ALU_SRAV = 6'd16, ALU_MULT = 6'd17, ALU_MULTU = 6'd18, ALU_DIV = 6'd19;
  localparam logic [5:0] ALU_DIVU = 6'd20, ALU_LUI = 6'd21, ALU_LB = 6'd22, ALU_LBU = 6'd23;
  localparam logic [5:0] ALU_LH = 6'd24,  ALU_LHU = 6'd25, ALU_LW = 6'd26,  ALU_SB = 6'd27;
  localparam logic [5:0] ALU_SH = 6'd28,  ALU_SW = 6'd29,  ALU_BREAK = 6'd30, ALU_SYSCALL = 6'd31;
  // HI/LO live outside the GPR (2'b00) and CP0 (2'b01) register spaces
  localparam logic [6:0] HI_ADDR = 7'h40, LO_ADDR = 7'h41;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        adel;
  } entry_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  alu;
    logic [6:0]  rs, rt, rd;
    logic [15:0] imm;
    logic        ri, adel, br, ds;
  } dec_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            prev_br_q;
  logic            vld_q, vld_d;
  dec_t            out_q, dec;
  logic            push, pop, unk, rsv;
  entry_t          head;
  logic [5:0]      op, fn;
  logic [4:0]      rs, rt, rd, sa;

  assign in_ready = (count_q < CW'(DEPTH));
  assign push     = in_valid & in_ready & ~flush;
  assign pop      = (count_q != '0) & (~vld_q | out_ready) & ~flush;
  assign head     = mem_q[rd_ptr_q];
  assign {op, rs, rt, rd, sa, fn} = head.ins;

  // Decode the FIFO head: ALU op, register mapping, branch and RI detection
  always_comb begin
    dec      = '0;
    dec.pc   = head.pc;
    dec.imm  = head.ins[15:0];
    dec.adel = head.adel;
    dec.rs   = {2'b00, rs};
    dec.rt   = {2'b00, rt};
    dec.rd   = {2'b00, rd};
    dec.alu  = ALU_NOP;
    unk      = 1'b0;
    rsv      = 1'b0;
    case (op)
      6'h00: case (fn)
        6'h00: begin dec.alu = ALU_SLL;  rsv = |rs; end
        6'h02: begin dec.alu = ALU_SRL;  rsv = |rs; end
        6'h03: begin dec.alu = ALU_SRA;  rsv = |rs; end
        6'h04: begin dec.alu = ALU_SLLV; rsv = |sa; end
        6'h06: begin dec.alu = ALU_SRLV; rsv = |sa; end
        6'h07: begin dec.alu = ALU_SRAV; rsv = |sa; end
        6'h08: begin dec.alu = ALU_ADD; dec.br = 1'b1; rsv = |{rt, rd, sa}; end
        6'h09: begin dec.alu = ALU_ADD; dec.br = 1'b1; rsv = |{rt, sa}; end
        6'h0C: dec.alu = ALU_SYSCALL;
        6'h0D: dec.alu = ALU_BREAK;
        6'h10: begin dec.alu = ALU_ADD; dec.rs = HI_ADDR; rsv = |{rs, rt, sa}; end
        6'h12: begin dec.alu = ALU_ADD; dec.rs = LO_ADDR; rsv = |{rs, rt, sa}; end
        6'h11: begin dec.alu = ALU_ADD; dec.rd = HI_ADDR; rsv = |{rt, rd, sa}; end
        6'h13: begin dec.alu = ALU_ADD; dec.rd = LO_ADDR; rsv = |{rt, rd, sa}; end
        6'h18: begin dec.alu = ALU_MULT;  rsv = |{rd, sa}; end
        6'h19: begin dec.alu = ALU_MULTU; rsv = |{rd, sa}; end
        6'h1A: begin dec.alu = ALU_DIV;   rsv = |{rd, sa}; end
        6'h1B: begin dec.alu = ALU_DIVU;  rsv = |{rd, sa}; end
        6'h20: begin dec.alu = ALU_ADD;  rsv = |sa; end
        6'h21: begin dec.alu = ALU_ADDU; rsv = |sa; end
        6'h22: begin dec.alu = ALU_SUB;  rsv = |sa; end
        6'h23: begin dec.alu = ALU_SUBU; rsv = |sa; end
        6'h24: begin dec.alu = ALU_AND;  rsv = |sa; end
        6'h25: begin dec.alu = ALU_OR;   rsv = |sa; end
        6'h26: begin dec.alu = ALU_XOR;  rsv = |sa; end
        6'h27: begin dec.alu = ALU_NOR;  rsv = |sa; end
        6'h2A: begin dec.alu = ALU_SLT;  rsv = |sa; end
        6'h2B: begin dec.alu = ALU_SLTU; rsv = |sa; end
        default: unk = 1'b1;
      endcase
      6'h01: begin
        dec.alu = ALU_ADD;
        dec.br  = 1'b1;
        rsv     = |head.ins[19:17];
        case (rt)
          5'h00, 5'h01: dec.rd = '0;
          5'h10, 5'h11: begin dec.rd = 7'd31; dec.rt = '0; end
          default: unk = 1'b1;
        endcase
      end
      6'h02: begin dec.alu = ALU_ADD; dec.br = 1'b1; dec.rd = '0; end
      6'h03: begin dec.alu = ALU_ADD; dec.br = 1'b1; dec.rs = '0; dec.rt = '0; dec.rd = 7'd31; end
      6'h04, 6'h05, 6'h06, 6'h07: begin dec.alu = ALU_ADD; dec.br = 1'b1; dec.rd = '0; end
      6'h08: dec.alu = ALU_ADD;
      6'h09: dec.alu = ALU_ADDU;
      6'h0A: dec.alu = ALU_SLT;
      6'h0B: dec.alu = ALU_SLTU;
      6'h0C: dec.alu = ALU_AND;
      6'h0D: dec.alu = ALU_OR;
      6'h0E: dec.alu = ALU_XOR;
      6'h0F: begin dec.alu = ALU_LUI; rsv = |rs; end
      6'h10: begin
        dec.alu = ALU_ADD;
        case (rs)
          5'h00: begin dec.rd = {2'b00, rt}; dec.rs = '0; dec.rt = {2'b01, rd}; rsv = |head.ins[10:0]; end
          5'h04: begin dec.rd = {2'b01, rd}; dec.rs = '0; rsv = |head.ins[10:0]; end
          5'h10: rsv = (|{rt, rd, sa}) | (fn != 6'h18);
          default: unk = 1'b1;
        endcase
      end
      6'h20: dec.alu = ALU_LB;
      6'h21: dec.alu = ALU_LH;
      6'h23: dec.alu = ALU_LW;
      6'h24: dec.alu = ALU_LBU;
      6'h25: dec.alu = ALU_LHU;
      6'h28: dec.alu = ALU_SB;
      6'h29: dec.alu = ALU_SH;
      6'h2B: dec.alu = ALU_SW;
      default: unk = 1'b1;
    endcase
    if (unk) dec.alu = ALU_NOP;
    dec.ri = unk | (RI_STRICT & rsv);
    dec.ds = prev_br_q;
  end

  // Next-state for occupancy and output valid; flush wins over everything
  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
    vld_d   = pop | (vld_q & ~out_ready);
    if (flush) begin
      count_d = '0;
      vld_d   = 1'b0;
    end
  end

  // FIFO storage; data needs no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{ins: in_ins, pc: in_pc, adel: in_adel};
  end

  // Pointers, occupancy, output register and branch history
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      vld_q     <= 1'b0;
      prev_br_q <= 1'b0;
      out_q     <= '0;
    end else begin
      count_q <= count_d;
      vld_q   <= vld_d;
      if (flush) begin
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        prev_br_q <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop) begin
          rd_ptr_q  <= rd_ptr_q + 1'b1;
          out_q     <= dec;
          prev_br_q <= dec.br;
        end
      end
    end
  end

  assign out_valid         = vld_q;
  assign out_pc            = out_q.pc;
  assign out_ALUop         = out_q.alu;
  assign out_Rs            = out_q.rs;
  assign out_Rt            = out_q.rt;
  assign out_Rd            = out_q.rd;
  assign out_imm           = out_q.imm;
  assign out_ri            = out_q.ri;
  assign out_adel          = out_q.adel;
  assign out_is_branch     = out_q.br;
  assign out_in_delay_slot = out_q.ds;
  assign count             = count_q;
endmodule
